// File: rtl/shift_add_mult_ctrl.sv
// Sequential shift-and-add multiplier control and datapath around an external adder.
// Optional build macro: SHIFT_ADD_EARLY_TERM_EN (stop once the remaining multiplier bits are zero).
module shift_add_mult_ctrl #(
    parameter int WORD_LENGTH = 4,
    parameter int WORD        = WORD_LENGTH * 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WORD_LENGTH-1:0] multiplicand,
    input  logic [WORD_LENGTH-1:0] multiplier,
    output logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic [WORD-1:0]        product,
    output logic [WORD-1:0]        add_a,
    output logic [WORD-1:0]        add_b,
    output logic                   add_cin,
    input  logic [WORD-1:0]        add_sum,
    input  logic                   add_cout
);

    localparam int CW = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WORD_LENGTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [WORD-1:0]        acc;
    logic [WORD-1:0]        mcand_reg;
    logic [WORD_LENGTH-1:0] mplier_reg;
    logic [CW-1:0]          count;
    logic                   last_iter;

`ifdef SHIFT_ADD_EARLY_TERM_EN
    assign last_iter = (count == LAST_COUNT) || ((mplier_reg >> 1) == '0);
`else
    assign last_iter = (count == LAST_COUNT);
`endif

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        add_a      = '0;
        add_b      = '0;
        add_cin    = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                add_a = acc;
                add_b = mplier_reg[0] ? mcand_reg : '0;
                if (last_iter) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Done is registered on the terminating edge so it coincides with the updated product.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc        <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            count      <= '0;
            product    <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc        <= '0;
                        mcand_reg  <= {{(WORD - WORD_LENGTH){1'b0}}, multiplicand};
                        mplier_reg <= multiplier;
                        count      <= '0;
                    end
                end
                RUN: begin
                    acc        <= add_sum;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    count      <= count + CW'(1);
                    if (last_iter) begin
                        product <= add_sum;
                        done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The product always fits in WORD bits, so the adder can never carry out while running.
    a_no_carry : assert property (@(posedge clk) disable iff (!reset) busy |-> !add_cout);

endmodule

// File: doc/shift_add_mult_ctrl.md
Name: shift_add_mult_ctrl

Overview:
- Sequential shift-and-add multiplier datapath and control for the Multiplier design.
- Sits directly upstream and downstream of the FullAdder stage. Each cycle it drives the adder's operand and carry inputs, then captures the adder's sum back into its accumulator.
- After WORD_LENGTH iterations it presents a WORD-bit unsigned product with a start/ready/done handshake.

Parameters:
- WORD_LENGTH, 4, width of each unsigned operand (multiplicand and multiplier).
- WORD, WORD_LENGTH*2, width of accumulator, adder operands and product.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- start  input  1  request to begin a multiplication; honoured only while ready=1.
- multiplicand  input  WORD_LENGTH  operand A; captured on the accepted start.
- multiplier  input  WORD_LENGTH  operand B; captured on the accepted start.
- ready  output  1  high in IDLE; block can accept start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; product is valid and updated.
- product  output  WORD  last completed result; held until the next completion.
- add_a  output  WORD  adder operand A = accumulator.
- add_b  output  WORD  adder operand B = shifted multiplicand, or 0.
- add_cin  output  1  adder carry-in; constant 0.
- add_sum  input  WORD  adder sum, combinational from add_a/add_b/add_cin.
- add_cout  input  1  adder carry-out; never expected high.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low: when reset=0 at a rising edge, all state clears.
- Reset values:
  - state=IDLE, acc=0, mcand_reg=0, mplier_reg=0, count=0.
  - product=0, done=0.
  - ready=1, busy=0.
  - add_a=0, add_b=0, add_cin=0.
- States: IDLE, RUN. Two states only; done is a registered pulse.
- IDLE:
  - ready=1, busy=0.
  - On start=1: mcand_reg <= zero-extended multiplicand; mplier_reg <= multiplier; acc <= 0; count <= 0; go to RUN.
- RUN:
  - ready=0, busy=1.
  - add_a = acc; add_b = mplier_reg[0] ? mcand_reg : 0; add_cin = 0.
  - Each edge: acc <= add_sum; mcand_reg <<= 1; mplier_reg >>= 1; count <= count+1.
- Termination:
  - Terminating edge is the one where count == WORD_LENGTH-1.
  - On that edge: product <= add_sum; done <= 1; state <= IDLE.
- Latency: start sampled on edge E0; done=1 and product valid in the cycle after edge E(WORD_LENGTH). For WORD_LENGTH=4, done is observed high at edge E5.
- done is high for exactly one cycle; ready is also high in that cycle.
- Back-to-back: start asserted while done=1 is accepted; no bubble required.
- start asserted while busy=1 is ignored. Operands are not re-captured.
- multiplicand/multiplier changes after capture have no effect on the running operation.
- Width rules:
  - All arithmetic is unsigned.
  - Maximum product (2^WL-1)^2 fits in WORD bits, so add_cout must be 0 every RUN cycle.
  - add_cout is not used in any computation.
- Reset mid-RUN: operation is abandoned; all reset values apply on the next edge, including product=0. No done pulse.
- add_a/add_b in IDLE: driven to 0.

Optional Feature:
- Macro: SHIFT_ADD_EARLY_TERM_EN.
- Defined:
  - In RUN, the terminating edge is the first edge where (mplier_reg >> 1) == 0 or count == WORD_LENGTH-1.
  - RUN length = max(1, position of the multiplier's highest set bit + 1) cycles.
  - A multiplier of 0 takes 1 RUN cycle.
- Not defined: RUN is always exactly WORD_LENGTH cycles, independent of operand values.
- Product value is identical in both builds; only done timing differs.

Test Plan:
- Max operands, WL=4: reset, then start with 15 x 15 -> done pulses once at edge E5, product=225 (0xE1); add_cout=0 in all cycles.
- Zero operands: 0 x 9 -> product=0. 7 x 0 -> product=0. With SHIFT_ADD_EARLY_TERM_EN, 7 x 0 gives done at edge E2 instead of E5.
- Small operands: 5 x 3 -> product=15. With SHIFT_ADD_EARLY_TERM_EN, done at edge E3; add_b sequence is 5, 10.
- Busy/back-to-back: start 6 x 7, pulse start with 2 x 2 mid-RUN -> ignored, product=42. Then start 9 x 11 in the done cycle -> accepted, product=99 four RUN cycles later.
- Reset mid-run: start 13 x 12, drive reset=0 at edge E2 -> next edge state=IDLE, product=0, done never pulses. Then 13 x 12 -> product=156.
- Reset synchronicity: drop reset between edges and release before the next edge -> no state change observed.
